g25_led_driver: RTL and testbench

Downstream consumer of the 10-bit LED PIO register in the SHA256 system. It takes the LED word written by the processor and drives the board LED pins. Each lit LED is dimmed by a global 4-bit PWM duty. With the flash feature compiled in, any LED whose register bit changes is forced fully on for a programmable hold time. The block sits between the LED PIO `out_port` and the top-level `LEDR[9:0]` pins.

---
 rtl/g25_led_driver.sv | 142 ++++++++++++++
 tb/tb_g25_led_driver.sv | 338 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/g25_led_driver.sv
// g25_led_driver: drives the board LEDs from the LED PIO register word.
// Every lit LED is dimmed by a global 4-bit PWM duty (15-tick period).
// Compile-time option G25_LED_FLASH_EN: any LED whose register bit changes
// is forced fully on for FLASH_TICKS PWM ticks, so set and clear events
// are both visible.
module g25_led_driver #(
  parameter int unsigned PRESCALE    = 50000,
  parameter int unsigned FLASH_TICKS = 250
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [9:0] led_word,
  input  logic [3:0] duty,
  output logic [9:0] led_out,
  output logic [9:0] flash_active
);

  localparam logic [15:0] PRE_LAST  = 16'(PRESCALE - 1);
  localparam logic [3:0]  PWM_LAST  = 4'd14;
  localparam logic [7:0]  HOLD_LOAD = 8'(FLASH_TICKS);

  logic [9:0]  led_q;
  logic [15:0] pre;
  logic        tick;
  logic [3:0]  pwm;
  logic        lvl;

  // Input register: one-cycle capture of the PIO word.
  always_ff @(posedge clk) begin
    if (reset) begin
      led_q <= '0;
    end else begin
      led_q <= led_word;
    end
  end

  // Prescaler: counts 0..PRESCALE-1 and wraps, tick on the last count.
  always_ff @(posedge clk) begin
    if (reset) begin
      pre <= '0;
    end else if (tick) begin
      pre <= '0;
    end else begin
      pre <= pre + 16'd1;
    end
  end

  // Tick strobe and PWM level decode.
  always_comb begin
    tick = (pre == PRE_LAST);
    lvl  = (pwm < duty);
  end

  // PWM phase counter: 0..14 per tick, so duty 15 is always on.
  always_ff @(posedge clk) begin
    if (reset) begin
      pwm <= '0;
    end else if (tick) begin
      if (pwm == PWM_LAST) begin
        pwm <= '0;
      end else begin
        pwm <= pwm + 4'd1;
      end
    end
  end

`ifdef G25_LED_FLASH_EN

  logic [9:0] led_prev;
  logic       q_valid;
  logic       primed;
  logic [9:0] chg;
  logic [7:0] hold [10];
  logic [9:0] hold_nz;

  // Change-detect stage. primed rises only once led_prev holds a word
  // sampled after reset, so the reset-to-first-value step never flashes.
  always_ff @(posedge clk) begin
    if (reset) begin
      led_prev <= '0;
      q_valid  <= 1'b0;
      primed   <= 1'b0;
    end else begin
      led_prev <= led_q;
      q_valid  <= 1'b1;
      primed   <= q_valid;
    end
  end

  // Qualified change vector and per-LED hold-active flags.
  always_comb begin
    chg     = '0;
    hold_nz = '0;
    if (primed) begin
      chg = led_q ^ led_prev;
    end
    for (int unsigned i = 0; i < 10; i++) begin
      hold_nz[i] = (hold[i] != 8'd0);
    end
  end

  // Per-LED hold counters: a change reloads (beats a same-cycle decrement),
  // otherwise count down once per tick until zero.
  always_ff @(posedge clk) begin
    for (int unsigned i = 0; i < 10; i++) begin
      if (reset) begin
        hold[i] <= '0;
      end else if (chg[i]) begin
        hold[i] <= HOLD_LOAD;
      end else if (tick && hold_nz[i]) begin
        hold[i] <= hold[i] - 8'd1;
      end
    end
  end

  // Output register: flashing LEDs are forced on regardless of their bit.
  always_ff @(posedge clk) begin
    if (reset) begin
      led_out      <= '0;
      flash_active <= '0;
    end else begin
      led_out      <= hold_nz | (led_q & {10{lvl}});
      flash_active <= hold_nz;
    end
  end

`else

  // Output register: plain PWM-dimmed LED word.
  always_ff @(posedge clk) begin
    if (reset) begin
      led_out <= '0;
    end else begin
      led_out <= led_q & {10{lvl}};
    end
  end

  assign flash_active = '0;

`endif

endmodule

// File: tb/tb_g25_led_driver.sv
// Directed testbench for g25_led_driver with PRESCALE=4, FLASH_TICKS=3.
// Flash scenarios run when G25_LED_FLASH_EN is defined for the build;
// otherwise the no-flash behaviour is checked instead.
module tb_g25_led_driver;

  logic       clk = 1'b0;
  logic       reset;
  logic [9:0] led_word;
  logic [3:0] duty;
  logic [9:0] led_out;
  logic [9:0] flash_active;

  int errors = 0;
  int checks = 0;
  int n = 0;   // non-reset edges since the last reset edge (prescaler phase)

  g25_led_driver #(.PRESCALE(4), .FLASH_TICKS(3)) dut (
    .clk          (clk),
    .reset        (reset),
    .led_word     (led_word),
    .duty         (duty),
    .led_out      (led_out),
    .flash_active (flash_active)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (reset) n <= 0;
    else       n <= n + 1;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic test_reset;
    reset = 1'b1; led_word = '0; duty = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++;
    if (led_out !== 10'h000) begin
      errors++; $display("FAIL reset_led_out got=%h exp=%h", led_out, 10'h000);
    end
    checks++;
    if (flash_active !== 10'h000) begin
      errors++; $display("FAIL reset_flash got=%h exp=%h", flash_active, 10'h000);
    end
  endtask

  task automatic test_latency;
    reset = 1'b0; led_word = 10'h3FF; duty = 4'd15;
    @(negedge clk);
    checks++;
    if (led_out !== 10'h000) begin
      errors++; $display("FAIL latency_edge1 got=%h exp=%h", led_out, 10'h000);
    end
    @(negedge clk);
    checks++;
    if (led_out !== 10'h3FF) begin
      errors++; $display("FAIL latency_edge2 got=%h exp=%h", led_out, 10'h3FF);
    end
    for (int i = 0; i < 20; i++) begin
      checks++;
      if (flash_active !== 10'h000) begin
        errors++; $display("FAIL prime_no_flash cyc=%0d got=%h exp=%h", i, flash_active, 10'h000);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_pwm;
    logic pat [60];
    int ones;
    int diffs;
    ones = 0; diffs = 0;
    duty = 4'd5; led_word = 10'h001;
    repeat (2) @(negedge clk);
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      pat[i] = led_out[0];
      if (led_out[0] === 1'b1) ones++;
    end
    checks++;
    if (ones !== 20) begin
      errors++; $display("FAIL pwm_duty5_count got=%0d exp=%0d", ones, 20);
    end
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (led_out[0] !== pat[i]) diffs++;
    end
    checks++;
    if (diffs !== 0) begin
      errors++; $display("FAIL pwm_period60 got=%0d exp=%0d differing clocks", diffs, 0);
    end
  endtask

  task automatic test_duty_bounds;
    int bad;
    bad = 0;
    duty = 4'd15;
    repeat (2) @(negedge clk);
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (led_out[0] !== 1'b1) bad++;
    end
    checks++;
    if (bad !== 0) begin
      errors++; $display("FAIL duty15_always_on got=%0d exp=%0d off clocks", bad, 0);
    end
    bad = 0;
    duty = 4'd0;
    repeat (2) @(negedge clk);
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (led_out[0] !== 1'b0) bad++;
    end
    checks++;
    if (bad !== 0) begin
      errors++; $display("FAIL duty0_always_off got=%0d exp=%0d on clocks", bad, 0);
    end
  endtask

  // Reset mid-PWM: the PWM restarts at phase 0, so led_out[0] is high on
  // edges 2..20 and again on 61..64 after the 14->0 wrap (23 of 64).
  task automatic test_reset_mid_pwm;
    int first;
    int cnt;
    first = -1; cnt = 0;
    duty = 4'd5;
    reset = 1'b1;
    @(negedge clk);
    checks++;
    if (led_out !== 10'h000) begin
      errors++; $display("FAIL rst_pwm_led_out got=%h exp=%h", led_out, 10'h000);
    end
    checks++;
    if (flash_active !== 10'h000) begin
      errors++; $display("FAIL rst_pwm_flash got=%h exp=%h", flash_active, 10'h000);
    end
    reset = 1'b0;
    for (int i = 1; i <= 64; i++) begin
      @(negedge clk);
      if (led_out[0] === 1'b1) begin
        cnt++;
        if (first < 0) first = i;
      end
    end
    checks++;
    if (first !== 2) begin
      errors++; $display("FAIL rst_pwm_first_on got=%0d exp=%0d", first, 2);
    end
    checks++;
    if (cnt !== 23) begin
      errors++; $display("FAIL rst_pwm_on_count got=%0d exp=%0d", cnt, 23);
    end
  endtask

  task automatic wait_phase(input int ph);
    int tries;
    tries = 0;
    while ((n % 4) != ph && tries < 8) begin
      @(negedge clk);
      tries++;
    end
    checks++;
    if ((n % 4) != ph) begin
      errors++; $display("FAIL phase_align got=%0d exp=%0d", n % 4, ph);
    end
  endtask

`ifdef G25_LED_FLASH_EN

  // Word applied with n%4==2: hold loads on a tick edge (reload wins), then
  // three further ticks -> flash_active[2] high on edges 3..14 (12 clocks).
  task automatic test_flash;
    int first;
    int cnt;
    int lcnt;
    first = -1; cnt = 0; lcnt = 0;
    duty = 4'd0; led_word = 10'h000;
    repeat (24) @(negedge clk);
    checks++;
    if (led_out !== 10'h000 || flash_active !== 10'h000) begin
      errors++; $display("FAIL flash_idle got=%h/%h exp=%h/%h", led_out, flash_active, 10'h000, 10'h000);
    end
    wait_phase(2);
    led_word = 10'h004;
    for (int i = 1; i <= 30; i++) begin
      @(negedge clk);
      if (flash_active[2] === 1'b1) begin
        cnt++;
        if (first < 0) first = i;
      end
      if (led_out[2] === 1'b1) lcnt++;
    end
    checks++;
    if (first !== 3) begin
      errors++; $display("FAIL flash_start got=%0d exp=%0d", first, 3);
    end
    checks++;
    if (cnt !== 12) begin
      errors++; $display("FAIL flash_len got=%0d exp=%0d", cnt, 12);
    end
    checks++;
    if (lcnt !== 12) begin
      errors++; $display("FAIL flash_led_len got=%0d exp=%0d", lcnt, 12);
    end
    checks++;
    if (led_out !== 10'h000 || flash_active !== 10'h000) begin
      errors++; $display("FAIL flash_end got=%h/%h exp=%h/%h", led_out, flash_active, 10'h000, 10'h000);
    end
  endtask

  // Second toggle lands after the first decrement: reload to 3 keeps the
  // flash alive, total high span edges 3..18 (16 clocks, 4 ticks).
  task automatic test_retrigger;
    int first;
    int last;
    int cnt;
    first = -1; last = -1; cnt = 0;
    wait_phase(2);
    led_word = 10'h000;
    for (int i = 1; i <= 30; i++) begin
      @(negedge clk);
      if (flash_active[2] === 1'b1) begin
        cnt++;
        last = i;
        if (first < 0) first = i;
      end
      if (i == 6) led_word = 10'h004;
    end
    checks++;
    if (first !== 3) begin
      errors++; $display("FAIL retrig_start got=%0d exp=%0d", first, 3);
    end
    checks++;
    if (cnt !== 16) begin
      errors++; $display("FAIL retrig_len got=%0d exp=%0d", cnt, 16);
    end
    checks++;
    if (last !== 18) begin
      errors++; $display("FAIL retrig_last got=%0d exp=%0d", last, 18);
    end
  endtask

  task automatic test_reset_flash;
    int bad;
    bad = 0;
    led_word = 10'h0F4;
    repeat (4) @(negedge clk);
    checks++;
    if (flash_active !== 10'h0F0) begin
      errors++; $display("FAIL mid_flash got=%h exp=%h", flash_active, 10'h0F0);
    end
    reset = 1'b1;
    @(negedge clk);
    checks++;
    if (led_out !== 10'h000 || flash_active !== 10'h000) begin
      errors++; $display("FAIL rst_flash_clear got=%h/%h exp=%h/%h", led_out, flash_active, 10'h000, 10'h000);
    end
    reset = 1'b0; duty = 4'd15;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (flash_active !== 10'h000) bad++;
    end
    checks++;
    if (bad !== 0) begin
      errors++; $display("FAIL rst_flash_no_reflash got=%0d exp=%0d flash clocks", bad, 0);
    end
    checks++;
    if (led_out !== 10'h0F4) begin
      errors++; $display("FAIL rst_flash_word got=%h exp=%h", led_out, 10'h0F4);
    end
  endtask

`else

  task automatic test_no_flash;
    logic prev_bit;
    int bad;
    bad = 0;
    duty = 4'd15;
    repeat (2) @(negedge clk);
    for (int t = 0; t < 4; t++) begin
      prev_bit = led_word[9];
      led_word[9] = ~led_word[9];
      @(negedge clk);
      checks++;
      if (led_out[9] !== prev_bit) begin
        errors++; $display("FAIL noflash_edge1 t=%0d got=%b exp=%b", t, led_out[9], prev_bit);
      end
      @(negedge clk);
      checks++;
      if (led_out[9] !== led_word[9]) begin
        errors++; $display("FAIL noflash_edge2 t=%0d got=%b exp=%b", t, led_out[9], led_word[9]);
      end
      checks++;
      if (flash_active !== 10'h000) begin
        errors++; $display("FAIL noflash_flash t=%0d got=%h exp=%h", t, flash_active, 10'h000);
      end
      repeat (t + 1) @(negedge clk);
    end
    duty = 4'd0;
    repeat (2) @(negedge clk);
    led_word[9] = ~led_word[9];
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (led_out !== 10'h000) bad++;
    end
    checks++;
    if (bad !== 0) begin
      errors++; $display("FAIL noflash_duty0 got=%0d exp=%0d lit clocks", bad, 0);
    end
  endtask

`endif

  initial begin
    test_reset;
    test_latency;
    test_pwm;
    test_duty_bounds;
    test_reset_mid_pwm;
`ifdef G25_LED_FLASH_EN
    test_flash;
    test_retrigger;
    test_reset_flash;
`else
    test_no_flash;
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
